// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer: drives clk_gen reset, qualifies lock with debounce/timeout/retry, then releases system reset
module clk_rst_sequencer #(
  parameter int PLL_RST_CYCLES      = 5,
  parameter int LOCK_STABLE_CYCLES  = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int RST_HOLD_CYCLES     = 8
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       locked,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_HOLD      = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;
  localparam int PW = $clog2((PLL_RST_CYCLES > RST_HOLD_CYCLES ? PLL_RST_CYCLES : RST_HOLD_CYCLES) + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  state_t state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0] retry_q, retry_d;
  logic [7:0] loss_q, loss_d;
  logic [1:0] sync_q;
  logic pll_rst_q, pll_rst_d, sys_rst_n_q, sys_rst_n_d, fault_q, fault_d;
  logic locked_s;
  assign locked_s = sync_q[1];
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    tmo_d    = tmo_q;
    retry_d  = retry_q;
    loss_d   = loss_q;
    if (soft_rst_req) begin
      state_d  = S_PLL_RST;
      cnt_d    = '0;
      stable_d = '0;
      tmo_d    = '0;
      retry_d  = '0;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          stable_d = '0;
          tmo_d    = '0;
          cnt_d    = (cnt_q == PW'(PLL_RST_CYCLES - 1)) ? '0 : cnt_q + PW'(1);
          state_d  = (cnt_q == PW'(PLL_RST_CYCLES - 1)) ? S_WAIT_LOCK : S_PLL_RST;
        end
        S_WAIT_LOCK: begin
          stable_d = locked_s ? stable_q + SW'(1) : '0;
          tmo_d    = tmo_q + TW'(1);
          if (locked_s && stable_q == SW'(LOCK_STABLE_CYCLES - 1)) state_d = S_HOLD;
          else if (tmo_q == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_q + 4'd1 == 4'(MAX_RETRIES)) ? S_FAULT : S_PLL_RST;
          end
        end
        S_HOLD: begin
          if (!locked_s) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
          end else if (cnt_q == PW'(RST_HOLD_CYCLES - 1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else cnt_d = cnt_q + PW'(1);
        end
        S_RUN: begin
          if (!locked_s) begin
            state_d = S_PLL_RST;
            loss_d  = (loss_q == 8'hff) ? loss_q : loss_q + 8'd1;
          end
        end
        S_FAULT: ;
        default: begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end
    pll_rst_d   = (state_d == S_PLL_RST) || (state_d == S_FAULT);
    sys_rst_n_d = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      stable_q    <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      sync_q      <= {sync_q[0], locked};
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      fault_q     <= fault_d;
    end
  end
  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign ready         = sys_rst_n_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;
  assign state         = state_q;
endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb_clk_rst_sequencer: vector table, directed corner sequences and randomized run against a cycle model
module tb_clk_rst_sequencer;
  localparam int PLL = 5, LSC = 16, LTC = 1024, MAXR = 3, HOLDC = 8;
  logic clk_in = 0, reset_in = 0, locked = 0, soft_rst_req = 0;
  logic pll_rst, sys_rst_n, ready, fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;
  int tests = 0, fails = 0;
  clk_rst_sequencer dut (
    .clk_in(clk_in), .reset_in(reset_in), .locked(locked), .soft_rst_req(soft_rst_req),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt), .state(state)
  );
  always #5 clk_in = ~clk_in;
  wire [18:0] dut_v = {pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_loss_cnt, state};
  int m_ph = 0, m_age = 0, m_run = 0, m_retry = 0, m_loss = 0;
  bit m_hist[$] = '{1'b0, 1'b0};
  task automatic m_goto(input int p);
    m_ph = p;
    m_age = 0;
    m_run = 0;
  endtask
  task automatic m_step(input bit r, input bit lk, input bit sr);
    bit ls;
    if (!r) begin
      m_goto(0);
      m_retry = 0;
      m_loss = 0;
      m_hist = '{1'b0, 1'b0};
      return;
    end
    ls = m_hist.pop_front();
    m_hist.push_back(lk);
    if (sr) begin
      m_goto(0);
      m_retry = 0;
      return;
    end
    case (m_ph)
      0: if (m_age + 1 == PLL) m_goto(1); else m_age++;
      1: begin
        m_run = ls ? m_run + 1 : 0;
        if (m_run == LSC) m_goto(2);
        else if (m_age + 1 == LTC) begin
          m_retry++;
          m_goto(m_retry == MAXR ? 4 : 0);
        end else m_age++;
      end
      2: if (!ls) m_goto(0);
         else if (m_age + 1 == HOLDC) begin
           m_goto(3);
           m_retry = 0;
         end else m_age++;
      3: if (!ls) begin
        if (m_loss < 255) m_loss++;
        m_goto(0);
      end
      default: ;
    endcase
  endtask
  function automatic logic [18:0] o(input bit p, input bit s, input bit f, input int rc, input int lc, input int st);
    return {p, s, s, f, 4'(rc), 8'(lc), 3'(st)};
  endfunction
  function automatic logic [18:0] m_exp();
    return o(m_ph == 0 || m_ph == 4, m_ph == 3, m_ph == 4, m_retry, m_loss, m_ph);
  endfunction
  task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic check_int(input string name, input int got, input int lo, input int hi);
    tests++;
    if (got < lo || got > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask
  task automatic cycle(input bit r, input bit lk, input bit sr);
    @(negedge clk_in);
    reset_in = r;
    locked = lk;
    soft_rst_req = sr;
    @(posedge clk_in);
    m_step(r, lk, sr);
    #1;
    check("model", dut_v, m_exp());
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      cycle(1, 1, 0);
      n++;
    end while (!ready && n < 200);
  endtask
  typedef struct {
    bit r;
    bit lk;
    bit sr;
    int n;
    logic [18:0] exp;
  } vec_t;
  vec_t tbl[14];
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n, rises, rseq;
    bit prev, sys_seen, lkv;
    tbl[0]  = '{0, 0, 0, 5,  o(1, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1, 0, 0, 4,  o(1, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1, 0, 0, 1,  o(0, 0, 0, 0, 0, 1)};
    tbl[3]  = '{1, 0, 0, 15, o(0, 0, 0, 0, 0, 1)};
    tbl[4]  = '{1, 1, 0, 17, o(0, 0, 0, 0, 0, 1)};
    tbl[5]  = '{1, 1, 0, 1,  o(0, 0, 0, 0, 0, 2)};
    tbl[6]  = '{1, 1, 0, 7,  o(0, 0, 0, 0, 0, 2)};
    tbl[7]  = '{1, 1, 0, 1,  o(0, 1, 0, 0, 0, 3)};
    tbl[8]  = '{1, 0, 0, 2,  o(0, 1, 0, 0, 0, 3)};
    tbl[9]  = '{1, 0, 0, 1,  o(1, 0, 0, 0, 1, 0)};
    tbl[10] = '{1, 1, 0, 5,  o(0, 0, 0, 0, 1, 1)};
    tbl[11] = '{1, 1, 0, 16, o(0, 0, 0, 0, 1, 2)};
    tbl[12] = '{1, 1, 0, 8,  o(0, 1, 0, 0, 1, 3)};
    tbl[13] = '{0, 1, 0, 1,  o(1, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < tbl[i].n; k++) cycle(tbl[i].r, tbl[i].lk, tbl[i].sr);
      check($sformatf("vec%0d", i), dut_v, tbl[i].exp);
    end
    repeat (10) cycle(1, 0, 0);
    repeat (10) cycle(1, 1, 0);
    cycle(1, 0, 0);
    wait_ready(n);
    check_int("debounce_restart", n, 25, 27);
    n = 0;
    do begin
      cycle(1, 0, 0);
      n++;
    end while (sys_rst_n && n < 10);
    check_int("lockloss_latency", n, 1, 3);
    check_int("lockloss_ready", int'(ready), 0, 0);
    check_int("lockloss_cnt", int'(lock_loss_cnt), 1, 1);
    n = 1;
    do begin
      cycle(1, 1, 0);
      if (pll_rst) n++;
    end while (pll_rst && n < 20);
    check_int("pll_pulse_len", n, 5, 5);
    wait_ready(n);
    check_int("rerun", n, 24, 24);
    cycle(0, 0, 0);
    n = 0;
    rises = 0;
    rseq = 0;
    sys_seen = 0;
    prev = pll_rst;
    do begin
      cycle(1, 0, 0);
      n++;
      if (pll_rst && !prev) begin
        rises++;
        rseq = rseq * 10 + int'(retry_cnt);
      end
      prev = pll_rst;
      sys_seen |= sys_rst_n;
    end while (!fault && n < 4000);
    check_int("fault_time", n, 3084, 3090);
    check_int("fault_retry_seq", rseq, 123, 123);
    check_int("fault_pulses", rises, 3, 3);
    check_int("fault_sysrst", int'(sys_seen), 0, 0);
    repeat (5) cycle(1, 0, 0);
    check("fault_held", dut_v, o(1, 0, 1, 3, 0, 4));
    cycle(1, 1, 1);
    check("soft_exit", dut_v, o(1, 0, 0, 0, 0, 0));
    wait_ready(n);
    check_int("soft_to_run", n, 29, 29);
    for (int i = 0; i < 4; i++) begin
      repeat (3) cycle(1, 0, 0);
      wait_ready(n);
    end
    check_int("loss4", int'(lock_loss_cnt), 4, 4);
    cycle(0, 1, 0);
    check("reset_in_run", dut_v, o(1, 0, 0, 0, 0, 0));
    repeat (12) cycle(1, 1, 0);
    check_int("in_wait", int'(state), 1, 1);
    cycle(0, 1, 0);
    check("reset_in_wait", dut_v, o(1, 0, 0, 0, 0, 0));
    wait_ready(n);
    repeat (2) cycle(1, 0, 0);
    cycle(1, 0, 1);
    check("soft_vs_loss", dut_v, o(1, 0, 0, 0, 0, 0));
    lkv = 1;
    for (int i = 0; i < 4000; i++) begin
      if (lkv) lkv = ($urandom_range(0, 99) != 0);
      else lkv = ($urandom_range(0, 9) == 0);
      cycle($urandom_range(0, 999) != 0, lkv, $urandom_range(0, 299) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
